// File: rtl/mips_multicycle_main_fsm.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable/select.
// Control outputs are decoded from the current state; the write strobes are
// additionally qualified by mem_ready/Zero and forced low while rst_n is low.
module mips_multicycle_main_fsm #(
   parameter int unsigned OP_WIDTH    = 6,
   parameter int unsigned ALUOP_WIDTH = 2,
   parameter int unsigned STATE_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [OP_WIDTH-1:0]    Op,
   input  logic                   Zero,
   input  logic                   mem_ready,
   output logic                   IorD,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic                   RegDst,
   output logic                   MemtoReg,
   output logic                   RegWrite,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [ALUOP_WIDTH-1:0] ALUOp,
   output logic [1:0]             PCSrc,
   output logic                   PCEn,
   output logic                   illegal_op,
   output logic [STATE_WIDTH-1:0] state_o
);

   localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
   localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
   localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
   localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
   localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
   localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);

   localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(2'b00);
   localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(2'b01);
   localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(2'b10);

   typedef enum logic [STATE_WIDTH-1:0] {
      FETCH   = STATE_WIDTH'(0),
      DECODE  = STATE_WIDTH'(1),
      MEMADR  = STATE_WIDTH'(2),
      MEMRD   = STATE_WIDTH'(3),
      MEMWB   = STATE_WIDTH'(4),
      MEMWR   = STATE_WIDTH'(5),
      RTYPEEX = STATE_WIDTH'(6),
      RTYPEWB = STATE_WIDTH'(7),
      BEQEX   = STATE_WIDTH'(8),
      ADDIEX  = STATE_WIDTH'(9),
      ADDIWB  = STATE_WIDTH'(10),
      JEX     = STATE_WIDTH'(11)
   } state_t;

   state_t state, state_n;
   logic   pc_write;
   logic   branch;

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_n;
   end

   // Next-state and control decode.
   always_comb begin
      state_n    = state;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = ALU_ADD;
      PCSrc      = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcB  = 2'b01;
            IRWrite  = mem_ready;
            pc_write = mem_ready;
            if (mem_ready) state_n = DECODE;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            if (Op == OP_LW || Op == OP_SW) state_n = MEMADR;
            else if (Op == OP_RTYPE)        state_n = RTYPEEX;
            else if (Op == OP_BEQ)          state_n = BEQEX;
            else if (Op == OP_ADDI)         state_n = ADDIEX;
            else if (Op == OP_J)            state_n = JEX;
            else begin
               illegal_op = 1'b1;
               state_n    = FETCH;
            end
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_n = (Op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            IorD = 1'b1;
            if (mem_ready) state_n = MEMWB;
         end
         MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            state_n  = FETCH;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) state_n = FETCH;
         end
         RTYPEEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_FUNCT;
            state_n = RTYPEWB;
         end
         RTYPEWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            state_n  = FETCH;
         end
         BEQEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_SUB;
            PCSrc   = 2'b01;
            branch  = 1'b1;
            state_n = FETCH;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_n = ADDIWB;
         end
         ADDIWB: begin
            RegWrite = 1'b1;
            state_n  = FETCH;
         end
         JEX: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
            state_n  = FETCH;
         end
         default: state_n = FETCH;
      endcase
      PCEn = pc_write | (branch & Zero);
      // Strobes must stay quiet for the whole reset assertion.
      if (!rst_n) begin
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         PCEn       = 1'b0;
         illegal_op = 1'b0;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_mips_multicycle_main_fsm.sv
// Testbench for the multi-cycle MIPS main control FSM.
module tb_mips_multicycle_main_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] Op;
   logic       Zero;
   logic       mem_ready;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSrc;
   logic       PCEn, illegal_op;
   logic [3:0] state_o;

   mips_multicycle_main_fsm dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
      .illegal_op(illegal_op), .state_o(state_o)
   );

   always #5 clk = ~clk;

   // ctrl = {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn,illegal_op}
   localparam logic [14:0] K_RST = {7'b0000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [14:0] K_F1  = {7'b0010000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [14:0] K_DEC = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [14:0] K_ILL = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
   localparam logic [14:0] K_MA  = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [14:0] K_MR  = {7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [14:0] K_MWB = {7'b0000110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [14:0] K_MW  = {7'b1100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [14:0] K_REX = {7'b0000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
   localparam logic [14:0] K_RWB = {7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [14:0] K_BQ1 = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
   localparam logic [14:0] K_BQ0 = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0};
   localparam logic [14:0] K_AWB = {7'b0000010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [14:0] K_J   = {7'b0000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BQ = 6'b000100, AD = 6'b001000, JJ = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   typedef struct packed {
      logic        rst_n;
      logic [5:0]  op;
      logic        zero;
      logic        mr;
      logic [3:0]  st;
      logic [14:0] ctrl;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   vec_idx = 0;

   function automatic logic [14:0] dut_ctrl();
      return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
              ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op};
   endfunction

   function automatic void add(logic r, logic [5:0] op, logic z, logic mr,
                               logic [3:0] st, logic [14:0] c);
      vec_t v;
      v.rst_n = r; v.op = op; v.zero = z; v.mr = mr; v.st = st; v.ctrl = c;
      tbl.push_back(v);
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
      end
   endtask

   // Scoreboard consumer: compares DUT outputs mid-cycle against the queued expectation.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         vec_t e;
         e = sb.pop_front();
         checks++;
         if (state_o !== e.st) begin
            failures++;
            $display("FAIL vec%0d state got=%0d want=%0d", vec_idx, state_o, e.st);
         end
         checks++;
         if (dut_ctrl() !== e.ctrl) begin
            failures++;
            $display("FAIL vec%0d ctrl got=%b want=%b", vec_idx, dut_ctrl(), e.ctrl);
         end
         vec_idx++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; Op = RT; Zero = 1'b0; mem_ready = 1'b1;

      add(0, RT, 0, 1, 0, K_RST);
      // lw: 5 cycles
      add(1, LW, 0, 1, 0, K_F1);  add(1, LW, 0, 1, 1, K_DEC);
      add(1, LW, 0, 1, 2, K_MA);  add(1, LW, 0, 1, 3, K_MR);
      add(1, LW, 0, 1, 4, K_MWB);
      // R-type with Zero high (must be ignored)
      add(1, RT, 1, 1, 0, K_F1);  add(1, RT, 1, 1, 1, K_DEC);
      add(1, RT, 1, 1, 6, K_REX); add(1, RT, 1, 1, 7, K_RWB);
      // beq taken / not taken
      add(1, BQ, 1, 1, 0, K_F1);  add(1, BQ, 1, 1, 1, K_DEC);
      add(1, BQ, 1, 1, 8, K_BQ1);
      add(1, BQ, 0, 1, 0, K_F1);  add(1, BQ, 0, 1, 1, K_DEC);
      add(1, BQ, 0, 1, 8, K_BQ0);
      // addi
      add(1, AD, 0, 1, 0, K_F1);  add(1, AD, 0, 1, 1, K_DEC);
      add(1, AD, 0, 1, 9, K_MA);  add(1, AD, 0, 1, 10, K_AWB);
      // fetch stall 3 cycles, then j
      add(1, JJ, 0, 0, 0, K_RST); add(1, JJ, 0, 0, 0, K_RST);
      add(1, JJ, 0, 0, 0, K_RST); add(1, JJ, 0, 1, 0, K_F1);
      add(1, JJ, 0, 1, 1, K_DEC); add(1, JJ, 0, 1, 11, K_J);
      // sw with one memory stall
      add(1, SW, 0, 1, 0, K_F1);  add(1, SW, 0, 1, 1, K_DEC);
      add(1, SW, 0, 1, 2, K_MA);  add(1, SW, 0, 0, 5, K_MW);
      add(1, SW, 0, 1, 5, K_MW);
      // lw with two read stalls
      add(1, LW, 0, 1, 0, K_F1);  add(1, LW, 0, 1, 1, K_DEC);
      add(1, LW, 0, 1, 2, K_MA);  add(1, LW, 0, 0, 3, K_MR);
      add(1, LW, 0, 0, 3, K_MR);  add(1, LW, 0, 1, 3, K_MR);
      add(1, LW, 0, 1, 4, K_MWB);
      // illegal opcode
      add(1, BAD, 1, 1, 0, K_F1); add(1, BAD, 1, 1, 1, K_ILL);
      add(1, BAD, 1, 1, 0, K_F1);

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         rst_n = tbl[i].rst_n; Op = tbl[i].op; Zero = tbl[i].zero;
         mem_ready = tbl[i].mr;
         sb.push_back(tbl[i]);
      end
      @(posedge clk); #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      // Async reset while a store is holding MemWrite in MEMWR.
      Op = SW; Zero = 1'b0; mem_ready = 1'b1;
      // Current state is DECODE (left by the final illegal sequence's FETCH).
      check("sw_decode_state", 32'(state_o), 32'd1);
      @(posedge clk); #1;
      check("sw_memadr_state", 32'(state_o), 32'd2);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      #1;
      check("memwr_state", 32'(state_o), 32'd5);
      check("memwr_strobe", 32'(MemWrite), 32'd1);
      @(posedge clk); #1;
      check("memwr_held_state", 32'(state_o), 32'd5);
      mem_ready = 1'b1;
      #1;
      check("memwr_ready_strobe", 32'(MemWrite), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_memwrite", 32'(MemWrite), 32'd0);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_irwrite", 32'(IRWrite), 32'd0);
      check("rst_pcen", 32'(PCEn), 32'd0);
      check("rst_alusrcb", 32'(ALUSrcB), 32'd1);
      @(posedge clk); #1;
      check("rst_hold_state", 32'(state_o), 32'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_irwrite", 32'(IRWrite), 32'd1);
      @(posedge clk); #1;
      check("post_rst_decode", 32'(state_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
